// File: rtl/ps2_host_rx.sv
// PS/2 device-to-host receiver: synchronises and filters the PS/2 lines, frames 11-bit
// packets, checks start/parity/stop and queues good bytes in a small FIFO.
module ps2_host_rx #(
  parameter int unsigned FILTER    = 8,
  parameter int unsigned TIMEOUT   = 2000,
  parameter int unsigned FIFO_BITS = 3
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       valid,
  output logic       busy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       overflow
);

  localparam int unsigned Depth = 2 ** FIFO_BITS;
  localparam int unsigned FW    = $clog2(FILTER + 1);
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);
  localparam int unsigned CW    = FIFO_BITS + 1;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          clk_f_q, clk_f_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall_q, fall_d;

  state_e        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] tocnt_q, tocnt_d;
  logic          push_q, push_d;
  logic          perr_q, perr_d, ferr_q, ferr_d, terr_q, terr_d, ovf_q, ovf_d;

  logic [7:0]           mem [Depth];
  logic [FIFO_BITS-1:0] wptr_q, rptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 pop, accept;

  // Filtered clock flips only after FILTER consecutive samples differing from it.
  always_comb begin
    fcnt_d  = '0;
    clk_f_d = clk_f_q;
    if (clk_s2_q != clk_f_q) begin
      if (fcnt_q == FW'(FILTER - 1)) clk_f_d = clk_s2_q;
      else                           fcnt_d  = fcnt_q + 1'b1;
    end
    fall_d = clk_f_q & ~clk_f_d;
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    push_d   = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    terr_d   = 1'b0;
    tocnt_d  = (state_q == StIdle || fall_q) ? '0 : tocnt_q + 1'b1;
    if (state_q != StIdle && tocnt_q == TW'(TIMEOUT)) begin
      terr_d  = 1'b1;
      state_d = StIdle;
      tocnt_d = '0;
    end else if (fall_q) begin
      case (state_q)
        StIdle: begin
          if (!dat_s2_q) begin
            state_d  = StData;
            bitcnt_d = '0;
            par_d    = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
        StData: begin
          shreg_d  = {dat_s2_q, shreg_q[7:1]};
          par_d    = par_q ^ dat_s2_q;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_d   = par_q ^ dat_s2_q;
          state_d = StStop;
        end
        StStop: begin
          if (!dat_s2_q)  ferr_d = 1'b1;
          else if (par_q) perr_d = 1'b1;
          else            push_d = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // shreg_q stays stable in IDLE long enough to serve as the push data.
  assign pop    = rd & (count_q != '0);
  assign accept = push_q & ((count_q != CW'(Depth)) | pop);
  assign ovf_d  = push_q & ~accept;

  always_comb begin
    count_d = count_q;
    if (accept & ~pop)      count_d = count_q + 1'b1;
    else if (pop & ~accept) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      clk_f_q  <= 1'b1;
      fcnt_q   <= '0;
      fall_q   <= 1'b0;
      state_q  <= StIdle;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      tocnt_q  <= '0;
      push_q   <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      terr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      clk_f_q  <= clk_f_d;
      fcnt_q   <= fcnt_d;
      fall_q   <= fall_d;
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      tocnt_q  <= tocnt_d;
      push_q   <= push_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      terr_q   <= terr_d;
      ovf_q    <= ovf_d;
      if (accept) wptr_q <= wptr_q + 1'b1;
      if (pop)    rptr_q <= rptr_q + 1'b1;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset_n && accept) mem[wptr_q] <= shreg_q;
  end

  assign dout        = mem[rptr_q];
  assign valid       = (count_q != '0);
  assign busy        = (state_q != StIdle);
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign timeout_err = terr_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_host_rx.sv
// Directed bench for ps2_host_rx: drives PS/2 frames, scoreboards received bytes and
// counts error pulses.
module tb_ps2_host_rx;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] dout;
  logic       valid, busy, parity_err, frame_err, timeout_err, overflow;

  int n_vec = 0;
  int n_err = 0;
  int c_par = 0, c_frm = 0, c_to = 0, c_ovf = 0;
  logic [7:0] sb_q[$];

  ps2_host_rx #(.FILTER(8), .TIMEOUT(2000), .FIFO_BITS(3)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd         (rd),
    .dout       (dout),
    .valid      (valid),
    .busy       (busy),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .timeout_err(timeout_err),
    .overflow   (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (parity_err)  c_par++;
    if (frame_err)   c_frm++;
    if (timeout_err) c_to++;
    if (overflow)    c_ovf++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Data changes mid-way through the high phase; 100-cycle half period.
  task automatic send_bit(input logic v);
    ps2_data = v;
    cyc(50);
    ps2_clk = 1'b0;
    cyc(100);
    ps2_clk = 1'b1;
    cyc(50);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ bad_par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    cyc(20);
  endtask

  task automatic drain(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      int guard = 0;
      while (!valid && guard < 500) begin
        cyc(1);
        guard++;
      end
      check({tag, "_valid"}, 32'(valid), 32'd1);
      if (sb_q.size() == 0) begin
        check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
        check({tag, "_dout"}, 32'(dout), 32'(sb_q.pop_front()));
      end
      rd = 1'b1;
      cyc(1);
      rd = 1'b0;
    end
  endtask

  initial begin
    int p0, f0, t0, o0;
    cyc(5);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_errs", 32'({parity_err, frame_err, timeout_err, overflow}), 32'd0);
    reset_n = 1'b1;
    cyc(5);

    // 1) good 0x1C
    sb_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t1_busy", 32'(busy), 32'd0);
    drain(1, "t1");
    check("t1_empty", 32'(valid), 32'd0);
    check("t1_noerr", 32'(c_par + c_frm + c_to + c_ovf), 32'd0);

    // 2) parity error then good 0xF0
    p0 = c_par;
    send_frame(8'h1C, 1'b1, 1'b0);
    check("t2_perr", 32'(c_par - p0), 32'd1);
    check("t2_valid", 32'(valid), 32'd0);
    sb_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b0);
    drain(1, "t2");

    // 3) bad stop bit
    f0 = c_frm;
    p0 = c_par;
    send_frame(8'h3C, 1'b0, 1'b1);
    check("t3_ferr", 32'(c_frm - f0), 32'd1);
    check("t3_no_perr", 32'(c_par - p0), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_valid", 32'(valid), 32'd0);

    // 4) timeout after 4 data bits
    t0 = c_to;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2_data = 1'b1;
    check("t4_busy_mid", 32'(busy), 32'd1);
    cyc(2100);
    check("t4_terr", 32'(c_to - t0), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    sb_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0);
    drain(1, "t4");

    // 5) overflow on ninth byte
    o0 = c_ovf;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) sb_q.push_back(8'(i));
      send_frame(8'(i), 1'b0, 1'b0);
      if (i == 8) check("t5_no_ovf", 32'(c_ovf - o0), 32'd0);
    end
    check("t5_ovf", 32'(c_ovf - o0), 32'd1);
    drain(8, "t5");
    check("t5_empty", 32'(valid), 32'd0);

    // 6) short glitch ignored; reset mid-frame
    f0 = c_frm;
    ps2_clk = 1'b0;
    cyc(3);
    ps2_clk = 1'b1;
    cyc(30);
    check("t6_glitch_busy", 32'(busy), 32'd0);
    check("t6_glitch_ferr", 32'(c_frm - f0), 32'd0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("t6_busy_mid", 32'(busy), 32'd1);
    reset_n = 1'b0;
    cyc(3);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_valid", 32'(valid), 32'd0);
    reset_n = 1'b1;
    cyc(20);
    sb_q.push_back(8'h33);
    send_frame(8'h33, 1'b0, 1'b0);
    drain(1, "t6");
    check("t6_sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
